// File: rtl/testbench_ls_timer_sched_pkg.sv
// Shared constants for the interval-timer scheduler: timer slave register map,
// control-word bit positions and the scheduler state encoding.
package testbench_ls_timer_sched_pkg;

  localparam logic [2:0] ADDR_STATUS   = 3'd0;
  localparam logic [2:0] ADDR_CONTROL  = 3'd1;
  localparam logic [2:0] ADDR_PERIOD_L = 3'd2;
  localparam logic [2:0] ADDR_PERIOD_H = 3'd3;

  localparam int unsigned CTRL_ITO   = 0;
  localparam int unsigned CTRL_CONT  = 1;
  localparam int unsigned CTRL_START = 2;
  localparam int unsigned CTRL_STOP  = 3;

  localparam logic [15:0] STOP_WORD  = 16'(1 << CTRL_STOP);
  // One-shot start: CONT left clear
  localparam logic [15:0] START_WORD = 16'((1 << CTRL_START) | (1 << CTRL_ITO) | (0 << CTRL_CONT));
  localparam logic [15:0] CLEAR_WORD = 16'h0000;

  typedef enum logic [3:0] {
    S_IDLE, S_ARB, S_STOP, S_WR_PL, S_WR_PH, S_SETTLE,
    S_START, S_WAIT, S_CLR, S_DONE, S_ABORT
  } state_e;

  function automatic logic [2:0] rr_next(input logic [2:0] id, input int unsigned n);
    return (({29'd0, id} + 32'd1) >= n) ? 3'd0 : id + 3'd1;
  endfunction

endpackage

// File: rtl/testbench_ls_timer_sched_rr_arb.sv
// Combinational round-robin grant: first asserted request at or after ptr,
// wrapping modulo N_REQ. The pointer register is owned by the parent.
module testbench_ls_timer_sched_rr_arb
  import testbench_ls_timer_sched_pkg::*;
#(
  parameter int unsigned N_REQ = 4
) (
  input  logic [N_REQ-1:0] req,
  input  logic [2:0]       ptr,
  output logic [2:0]       gnt_id,
  output logic             gnt_valid
);

  always_comb begin
    gnt_id    = '0;
    gnt_valid = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      for (int unsigned j = 0; j < N_REQ; j++) begin
        if (!gnt_valid && req[j] && (j == ({29'd0, ptr} + i) % N_REQ)) begin
          gnt_id    = 3'(j);
          gnt_valid = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/testbench_ls_timer_sched.sv
// Shares one interval timer among N_REQ one-shot timeout requesters over the
// timer's Avalon-MM slave. Optional watchdog abort: define TMR_SCHED_WDOG_EN.
module testbench_ls_timer_sched
  import testbench_ls_timer_sched_pkg::*;
#(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned WDOG_W = 24
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_REQ-1:0]    req,
  input  logic [32*N_REQ-1:0] req_period,
  input  logic [N_REQ-1:0]    cancel,
  output logic [N_REQ-1:0]    done,
  output logic [N_REQ-1:0]    err,
  output logic                busy,
  output logic [2:0]          grant_id,
  output logic [2:0]          tmr_address,
  output logic                tmr_chipselect,
  output logic                tmr_write_n,
  output logic [15:0]         tmr_writedata,
  input  logic                tmr_irq
);

  state_e      state_q, state_d;
  logic [2:0]  ptr_q, ptr_d;
  logic [2:0]  grant_q, grant_d;
  logic [31:0] period_q, period_d;
  logic        abort_q, abort_d;
  logic        wdog_q, wdog_d;

  logic [2:0]  arb_id;
  logic        arb_valid;
  logic [31:0] arb_period;
  logic        owner_req, owner_cancel, kill;
  logic        wdog_hit;

  testbench_ls_timer_sched_rr_arb #(.N_REQ(N_REQ)) u_arb (
    .req       (req),
    .ptr       (ptr_q),
    .gnt_id    (arb_id),
    .gnt_valid (arb_valid)
  );

  always_comb begin
    owner_req    = 1'b0;
    owner_cancel = 1'b0;
    arb_period   = '0;
    for (int unsigned j = 0; j < N_REQ; j++) begin
      if (grant_q == 3'(j)) begin
        owner_req    = req[j];
        owner_cancel = cancel[j];
      end
      if (arb_id == 3'(j)) arb_period = req_period[32*j +: 32];
    end
  end

  // Owner dropping its request is handled exactly like a cancel
  assign kill = owner_cancel | ~owner_req;

`ifdef TMR_SCHED_WDOG_EN
  logic [WDOG_W-1:0] wdog_cnt_q, wdog_cnt_d;

  always_comb begin
    wdog_cnt_d = wdog_cnt_q;
    if (state_q == S_START)     wdog_cnt_d = '0;
    else if (state_q == S_WAIT) wdog_cnt_d = wdog_cnt_q + {{(WDOG_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) wdog_cnt_q <= '0;
    else       wdog_cnt_q <= wdog_cnt_d;
  end

  assign wdog_hit = (state_q == S_WAIT) && (wdog_cnt_q == '1);
`else
  assign wdog_hit = 1'b0;
`endif

  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    grant_d        = grant_q;
    period_d       = period_q;
    abort_d        = abort_q;
    wdog_d         = wdog_q;
    tmr_address    = '0;
    tmr_chipselect = 1'b0;
    tmr_write_n    = 1'b1;
    tmr_writedata  = '0;
    done           = '0;
    err            = '0;
    unique case (state_q)
      S_IDLE: if (|req) state_d = S_ARB;
      S_ARB: begin
        if (arb_valid) begin
          grant_d  = arb_id;
          period_d = (arb_period == '0) ? 32'd1 : arb_period;
          abort_d  = 1'b0;
          wdog_d   = 1'b0;
          state_d  = S_STOP;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_STOP: begin
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
        tmr_address    = ADDR_CONTROL;
        tmr_writedata  = STOP_WORD;
        state_d        = kill ? S_ABORT : S_WR_PL;
      end
      S_WR_PL: begin
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
        tmr_address    = ADDR_PERIOD_L;
        tmr_writedata  = period_q[15:0];
        state_d        = kill ? S_ABORT : S_WR_PH;
      end
      S_WR_PH: begin
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
        tmr_address    = ADDR_PERIOD_H;
        tmr_writedata  = period_q[31:16];
        state_d        = kill ? S_ABORT : S_SETTLE;
      end
      // Timer's registered force_reload lands here; a START now would be lost
      S_SETTLE: state_d = kill ? S_ABORT : S_START;
      S_START: begin
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
        tmr_address    = ADDR_CONTROL;
        tmr_writedata  = START_WORD;
        state_d        = kill ? S_ABORT : S_WAIT;
      end
      S_WAIT: begin
        if (kill) begin
          state_d = S_ABORT;
        end else if (tmr_irq) begin
          state_d = S_CLR;
        end else if (wdog_hit) begin
          wdog_d  = 1'b1;
          state_d = S_ABORT;
        end
      end
      S_ABORT: begin
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
        tmr_address    = ADDR_CONTROL;
        tmr_writedata  = STOP_WORD;
        abort_d        = 1'b1;
        state_d        = S_CLR;
      end
      S_CLR: begin
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
        tmr_address    = ADDR_STATUS;
        tmr_writedata  = CLEAR_WORD;
        // A cancelled grant ends silently; completion and watchdog report in DONE
        if (abort_q && !wdog_q) begin
          ptr_d   = rr_next(grant_q, N_REQ);
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        for (int unsigned j = 0; j < N_REQ; j++) begin
          if (grant_q == 3'(j)) begin
            done[j] = ~wdog_q;
            err[j]  = wdog_q;
          end
        end
        ptr_d   = rr_next(grant_q, N_REQ);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      grant_q  <= '0;
      period_q <= '0;
      abort_q  <= 1'b0;
      wdog_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      grant_q  <= grant_d;
      period_q <= period_d;
      abort_q  <= abort_d;
      wdog_q   <= wdog_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign grant_id = grant_q;

endmodule

// File: tb/tb_testbench_ls_timer_sched.sv
// Self-checking bench for testbench_ls_timer_sched with a behavioural timer
// slave and a round-robin reference model. Define TMR_SCHED_WDOG_EN to add the watchdog test.
module tb_testbench_ls_timer_sched;

  localparam int N = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    req = '0;
  logic [32*N-1:0] req_period = '0;
  logic [N-1:0]    cancel = '0;
  logic [N-1:0]    done, err;
  logic            busy;
  logic [2:0]      grant_id, tmr_address;
  logic            tmr_chipselect, tmr_write_n;
  logic [15:0]     tmr_writedata;
  logic            tmr_irq;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  testbench_ls_timer_sched #(.N_REQ(N), .WDOG_W(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .req            (req),
    .req_period     (req_period),
    .cancel         (cancel),
    .done           (done),
    .err            (err),
    .busy           (busy),
    .grant_id       (grant_id),
    .tmr_address    (tmr_address),
    .tmr_chipselect (tmr_chipselect),
    .tmr_write_n    (tmr_write_n),
    .tmr_writedata  (tmr_writedata),
    .tmr_irq        (tmr_irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Behavioural interval timer: one-shot countdown, status cleared by any status write
  logic [15:0] m_pl = '0, m_ph = '0;
  logic [31:0] m_cnt = '0;
  logic        m_run = 1'b0, m_to = 1'b0, m_ito = 1'b0;
  logic        irq_en = 1'b1;

  always @(posedge clk) begin
    if (tmr_chipselect && !tmr_write_n) begin
      case (tmr_address)
        3'd0: m_to <= 1'b0;
        3'd1: begin
          m_ito <= tmr_writedata[0];
          if (tmr_writedata[3]) m_run <= 1'b0;
          else if (tmr_writedata[2]) begin
            m_run <= 1'b1;
            m_cnt <= {m_ph, m_pl};
          end
        end
        3'd2: m_pl <= tmr_writedata;
        3'd3: m_ph <= tmr_writedata;
        default: ;
      endcase
    end else if (m_run) begin
      if (m_cnt == 32'd0) begin
        m_to  <= 1'b1;
        m_run <= 1'b0;
      end else begin
        m_cnt <= m_cnt - 32'd1;
      end
    end
  end

  assign tmr_irq = m_to & m_ito & irq_en;

  // Bus / pulse monitor
  typedef struct { int c; int a; int d; } wr_t;
  wr_t wr_q[$];
  int  done_c[$];
  int  err_c[$];
  int  irq_c = -1000;
  logic irq_prev = 1'b0;
  wr_t w;

  always @(negedge clk) begin
    if (tmr_chipselect && !tmr_write_n) begin
      w.c = cyc;
      w.a = int'(tmr_address);
      w.d = int'(tmr_writedata);
      wr_q.push_back(w);
    end
    if (|done) done_c.push_back(cyc);
    if (|err)  err_c.push_back(cyc);
    if (tmr_irq && !irq_prev) irq_c = cyc;
    irq_prev = tmr_irq;
  end

  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic int vec_idx(input logic [N-1:0] v);
    for (int k = 0; k < N; k++) if (v[k]) return k;
    return -1;
  endfunction

  task automatic clear_logs();
    #1;
    wr_q.delete();
    done_c.delete();
    err_c.delete();
    irq_c = -1000;
  endtask

  task automatic set_period(input int i, input logic [31:0] p);
    req_period[32*i +: 32] = p;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req = '0;
    cancel = '0;
    irq_en = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    clear_logs();
  endtask

  task automatic wait_pulse(input int limit, output bit ok);
    ok = 1'b0;
    for (int t = 0; t < limit; t++) begin
      @(negedge clk);
      if (|done || |err) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_start(input int limit, output bit ok);
    ok = 1'b0;
    for (int t = 0; t < limit; t++) begin
      @(negedge clk);
      if (tmr_chipselect && !tmr_write_n && tmr_address == 3'd1 && tmr_writedata == 16'h0005) begin
        ok = 1'b1; break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clk);
    checks++; if (done !== '0) begin errors++; $display("FAIL reset_done got=%h want=0", done); end
    checks++; if (err !== '0) begin errors++; $display("FAIL reset_err got=%h want=0", err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (grant_id !== 3'd0) begin errors++; $display("FAIL reset_grant got=%0d want=0", grant_id); end
    checks++; if (tmr_address !== 3'd0) begin errors++; $display("FAIL reset_addr got=%0d want=0", tmr_address); end
    checks++; if (tmr_chipselect !== 1'b0) begin errors++; $display("FAIL reset_cs got=%b want=0", tmr_chipselect); end
    checks++; if (tmr_write_n !== 1'b1) begin errors++; $display("FAIL reset_write_n got=%b want=1", tmr_write_n); end
    checks++; if (tmr_writedata !== 16'd0) begin errors++; $display("FAIL reset_wdata got=%h want=0", tmr_writedata); end
  endtask

  task automatic test_single();
    bit ok;
    int ea[5] = '{1, 2, 3, 1, 0};
    int ed[5] = '{8, 16, 0, 5, 0};
    do_reset();
    set_period(0, 32'h0000_0010);
    req = 4'b0001;
    wait_pulse(200, ok);
    req = '0;
    #1;
    checks++; if (!ok) begin errors++; $display("FAIL single_timeout got=none want=pulse"); end
    checks++; if (done !== 4'b0001) begin errors++; $display("FAIL single_done got=%b want=0001", done); end
    checks++;
    if (wr_q.size() != 5) begin
      errors++; $display("FAIL single_nwrites got=%0d want=5", wr_q.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (wr_q[k].a != ea[k] || wr_q[k].d != ed[k]) begin
          errors++; $display("FAIL single_write%0d got=(%0d,%h) want=(%0d,%h)", k, wr_q[k].a, wr_q[k].d, ea[k], ed[k]);
        end
      end
      checks++; if (wr_q[1].c - wr_q[0].c != 1 || wr_q[2].c - wr_q[0].c != 2 || wr_q[3].c - wr_q[0].c != 4) begin
        errors++; $display("FAIL single_spacing got=%0d,%0d,%0d want=1,2,4", wr_q[1].c - wr_q[0].c, wr_q[2].c - wr_q[0].c, wr_q[3].c - wr_q[0].c);
      end
      checks++; if (wr_q[4].c != irq_c + 1) begin errors++; $display("FAIL single_clr_cycle got=%0d want=%0d", wr_q[4].c, irq_c + 1); end
    end
    checks++; if (done_c.size() != 1 || done_c[0] - irq_c != 2) begin
      errors++; $display("FAIL single_irq_to_done got=n%0d lat%0d want=n1 lat2", done_c.size(), (done_c.size() > 0) ? done_c[0] - irq_c : -1);
    end
  endtask

  task automatic test_fairness();
    bit ok;
    int exp_order[5] = '{0, 1, 2, 3, 0};
    do_reset();
    for (int i = 0; i < N; i++) set_period(i, 32'd5);
    req = 4'b1111;
    for (int r = 0; r < 5; r++) begin
      wait_pulse(200, ok);
      checks++; if (!ok) begin errors++; $display("FAIL fair_timeout round=%0d", r); end
      checks++; if ($countones(done) != 1 || vec_idx(done) != exp_order[r]) begin
        errors++; $display("FAIL fair_order round=%0d got=%b want_idx=%0d", r, done, exp_order[r]);
      end
    end
    req = '0;
    #1;
    checks++; if (done_c.size() != 5 || wr_q.size() != 25) begin
      errors++; $display("FAIL fair_counts got=done%0d wr%0d want=done5 wr25", done_c.size(), wr_q.size());
    end
  endtask

  task automatic test_cancel_wait();
    bit ok;
    int c0;
    do_reset();
    set_period(2, 32'd200);
    req = 4'b0100;
    wait_start(50, ok);
    checks++; if (!ok) begin errors++; $display("FAIL cancel_start_timeout"); end
    repeat (3) @(negedge clk);
    cancel = 4'b0100;
    c0 = cyc;
    @(negedge clk);
    cancel = '0;
    req = '0;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cancel_busy got=%b want=0", busy); end
    repeat (5) @(negedge clk);
    #1;
    checks++;
    if (wr_q.size() != 6) begin
      errors++; $display("FAIL cancel_nwrites got=%0d want=6", wr_q.size());
    end else begin
      checks++; if (wr_q[4].a != 1 || wr_q[4].d != 8 || wr_q[4].c != c0 + 1) begin
        errors++; $display("FAIL cancel_stop got=(%0d,%h)@%0d want=(1,0008)@%0d", wr_q[4].a, wr_q[4].d, wr_q[4].c, c0 + 1);
      end
      checks++; if (wr_q[5].a != 0 || wr_q[5].d != 0 || wr_q[5].c != c0 + 2) begin
        errors++; $display("FAIL cancel_clr got=(%0d,%h)@%0d want=(0,0000)@%0d", wr_q[5].a, wr_q[5].d, wr_q[5].c, c0 + 2);
      end
    end
    checks++; if (done_c.size() != 0) begin errors++; $display("FAIL cancel_no_done got=%0d want=0", done_c.size()); end
    // Pointer moved past 2, so 3 beats 1
    set_period(1, 32'd3);
    set_period(3, 32'd3);
    req = 4'b1010;
    wait_pulse(200, ok);
    req = '0;
    checks++; if (!ok || done !== 4'b1000) begin errors++; $display("FAIL cancel_ptr got=%b want=1000", done); end
  endtask

  task automatic test_period_zero();
    bit ok;
    do_reset();
    set_period(1, 32'd0);
    req = 4'b0010;
    wait_pulse(200, ok);
    req = '0;
    #1;
    checks++; if (!ok || done !== 4'b0010) begin errors++; $display("FAIL pzero_done got=%b want=0010", done); end
    checks++;
    if (wr_q.size() != 5) begin
      errors++; $display("FAIL pzero_nwrites got=%0d want=5", wr_q.size());
    end else begin
      checks++; if (wr_q[1].a != 2 || wr_q[1].d != 1) begin errors++; $display("FAIL pzero_pl got=(%0d,%h) want=(2,0001)", wr_q[1].a, wr_q[1].d); end
      checks++; if (wr_q[2].a != 3 || wr_q[2].d != 0) begin errors++; $display("FAIL pzero_ph got=(%0d,%h) want=(3,0000)", wr_q[2].a, wr_q[2].d); end
    end
  endtask

  task automatic test_irq_cancel();
    bit ok;
    int c0;
    do_reset();
    set_period(0, 32'd3);
    req = 4'b0001;
    ok = 1'b0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (tmr_irq) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin errors++; $display("FAIL irqcan_irq_timeout"); end
    cancel = 4'b0001;
    c0 = cyc;
    @(negedge clk);
    cancel = '0;
    req = '0;
    repeat (6) @(negedge clk);
    #1;
    checks++; if (done_c.size() != 0) begin errors++; $display("FAIL irqcan_no_done got=%0d want=0", done_c.size()); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL irqcan_busy got=%b want=0", busy); end
    checks++;
    if (wr_q.size() != 6) begin
      errors++; $display("FAIL irqcan_nwrites got=%0d want=6", wr_q.size());
    end else if (wr_q[4].a != 1 || wr_q[4].d != 8 || wr_q[4].c != c0 + 1 || wr_q[5].a != 0 || wr_q[5].c != c0 + 2) begin
      errors++; $display("FAIL irqcan_abort got=(%0d,%h)@%0d (%0d)@%0d want=(1,0008)@%0d (0)@%0d",
                         wr_q[4].a, wr_q[4].d, wr_q[4].c, wr_q[5].a, wr_q[5].c, c0 + 1, c0 + 2);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_reset();
    set_period(3, 32'd60);
    req = 4'b1000;
    wait_start(50, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rstmid_start_timeout"); end
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || tmr_chipselect !== 1'b0 || tmr_write_n !== 1'b1 || grant_id !== 3'd0 || done !== '0) begin
      errors++; $display("FAIL rstmid_outputs got=busy%b cs%b wn%b gid%0d done%b want=busy0 cs0 wn1 gid0 done0",
                         busy, tmr_chipselect, tmr_write_n, grant_id, done);
    end
    reset = 1'b0;
    clear_logs();
    wait_pulse(300, ok);
    req = '0;
    #1;
    checks++; if (!ok || done !== 4'b1000) begin errors++; $display("FAIL rstmid_done got=%b want=1000", done); end
    checks++; if (wr_q.size() != 5 || wr_q[0].a != 1 || wr_q[0].d != 8) begin
      errors++; $display("FAIL rstmid_restart got=n%0d want=n5 first=(1,0008)", wr_q.size());
    end
  endtask

  task automatic test_random();
    bit ok;
    logic [N-1:0] pend;
    logic [31:0]  per [N];
    logic [31:0]  pe;
    int ptr_m, exp_id;
    do_reset();
    ptr_m = 0;
    pend = '0;
    for (int i = 0; i < N; i++) begin
      per[i] = 32'($urandom_range(0, 10));
      set_period(i, per[i]);
    end
    pend = 4'($urandom_range(1, 15));
    for (int r = 0; r < 30; r++) begin
      req = pend;
      exp_id = rr_pick(pend, ptr_m);
      clear_logs();
      wait_pulse(200, ok);
      checks++; if (!ok) begin errors++; $display("FAIL rand_timeout round=%0d", r); end
      checks++; if ($countones(done) != 1 || vec_idx(done) != exp_id) begin
        errors++; $display("FAIL rand_grant round=%0d got=%b want_idx=%0d", r, done, exp_id);
      end
      if (exp_id >= 0) pend[exp_id] = 1'b0;
      req = pend;
      #1;
      pe = (per[exp_id] == 32'd0) ? 32'd1 : per[exp_id];
      checks++;
      if (wr_q.size() != 5) begin
        errors++; $display("FAIL rand_nwrites round=%0d got=%0d want=5", r, wr_q.size());
      end else if (wr_q[0].d != 8 || wr_q[1].d != int'(pe[15:0]) || wr_q[2].d != int'(pe[31:16]) ||
                   wr_q[3].d != 5 || wr_q[4].a != 0) begin
        errors++; $display("FAIL rand_writes round=%0d got=%h,%h,%h,%h want=0008,%h,%h,0005", r,
                           wr_q[0].d, wr_q[1].d, wr_q[2].d, wr_q[3].d, pe[15:0], pe[31:16]);
      end
      checks++; if (done_c.size() != 1 || done_c[0] - irq_c != 2) begin
        errors++; $display("FAIL rand_latency round=%0d got=n%0d irq%0d want=n1 lat2", r, done_c.size(), irq_c);
      end
      ptr_m = (exp_id + 1) % N;
      for (int j = 0; j < N; j++) begin
        if (!pend[j] && $urandom_range(0, 1) == 1) begin
          pend[j] = 1'b1;
          per[j] = 32'($urandom_range(0, 10));
          set_period(j, per[j]);
        end
      end
      if (pend == '0) pend[0] = 1'b1;
      req = pend;
    end
    req = '0;
    checks++; if (err_c.size() != 0) begin errors++; $display("FAIL rand_no_err got=%0d want=0", err_c.size()); end
  endtask

`ifdef TMR_SCHED_WDOG_EN
  task automatic test_wdog();
    bit ok;
    int s;
    do_reset();
    irq_en = 1'b0;
    set_period(0, 32'd5);
    req = 4'b0001;
    wait_start(50, ok);
    s = cyc;
    wait_pulse(100, ok);
    req = '0;
    #1;
    checks++; if (!ok || err !== 4'b0001 || done !== '0) begin errors++; $display("FAIL wdog_err got=err%b done%b want=err0001 done0", err, done); end
    checks++;
    if (wr_q.size() != 6) begin
      errors++; $display("FAIL wdog_nwrites got=%0d want=6", wr_q.size());
    end else if (wr_q[4].a != 1 || wr_q[4].d != 8 || wr_q[5].a != 0 || wr_q[4].c - s < 16 || wr_q[4].c - s > 17) begin
      errors++; $display("FAIL wdog_abort got=(%0d,%h) delay=%0d want=(1,0008) delay=16..17", wr_q[4].a, wr_q[4].d, wr_q[4].c - s);
    end
    irq_en = 1'b1;
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL global_timeout at cycle %0d", cyc);
    $fatal(1, "bench stopped by time limit");
  end

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_cancel_wait();
    test_period_zero();
    test_irq_cancel();
    test_reset_mid();
    test_random();
`ifdef TMR_SCHED_WDOG_EN
    test_wdog();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
